// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receive controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    WAIT_ACK,
    WAIT_IDLE,
    FAIL
  } ps2_tx_state_t;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_FRAME_FALLS = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// PS/2 line synchronizer with falling-edge detect on the clock line.
// Latency: SYNC_STAGES cycles to clk_s/data_s; fall is combinational from the last stage.
// Backpressure: none; free-running sampler.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_i,
  input  logic data_i,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], clk_i};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], data_i};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sr[SYNC_STAGES-1];
  assign data_s = data_sr[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked shift, ack.
// Latency: INHIBIT_CYCLES plus 11 device clock periods per attempt; done/err are one-cycle pulses.
// Backpressure: tx_ready low while busy; PS2_HOST_TX_RETRY_EN resends up to twice before err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       PARITY_IDX = 4'(PS2_DATA_BITS);
  localparam logic [3:0]       STOP_IDX   = 4'(PS2_FRAME_FALLS - 2);

  ps2_tx_state_t    state;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             clk_s;
  logic             data_s;
  logic             fall;
  logic             timed;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]       retry_cnt;
`endif

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_i  (ps2_clk_i),
    .data_i (ps2_data_i),
    .clk_s  (clk_s),
    .data_s (data_s),
    .fall   (fall)
  );

  assign timed = (state == SHIFT) || (state == WAIT_ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (timed && tmo_cnt == TMO_LAST) begin
        state <= FAIL;
      end else begin
        if (timed) tmo_cnt <= tmo_cnt + TMO_W'(1);
        case (state)
          IDLE: begin
            if (tx_valid) begin
              byte_q     <= tx_data;
              parity_q   <= odd_parity(tx_data);
              ps2_clk_oe <= 1'b1;
              inh_cnt    <= INH_W'(1);
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
              retry_cnt  <= '0;
`endif
            end
          end
          // Counting starts at 1 so the clock is held low for exactly INHIBIT_CYCLES, RTS included.
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= RTS;
            end else begin
              inh_cnt <= inh_cnt + INH_W'(1);
            end
          end
          RTS: begin
            ps2_clk_oe <= 1'b0;
            tmo_cnt    <= '0;
            bit_idx    <= '0;
            state      <= SHIFT;
          end
          SHIFT: begin
            if (fall) begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx < PARITY_IDX) begin
                ps2_data_oe <= ~byte_q[bit_idx[2:0]];
              end else if (bit_idx == PARITY_IDX) begin
                ps2_data_oe <= ~parity_q;
              end else if (bit_idx == STOP_IDX) begin
                ps2_data_oe <= 1'b0;
                state       <= WAIT_ACK;
              end
            end
          end
          WAIT_ACK: begin
            if (fall) state <= data_s ? FAIL : WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              done     <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
          FAIL: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_cnt != 2'd2) begin
              retry_cnt  <= retry_cnt + 2'd1;
              ps2_clk_oe <= 1'b1;
              inh_cnt    <= INH_W'(1);
              state      <= INHIBIT;
            end else begin
              err      <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
`else
            err      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a device model that clocks frames and acks/nacks.
module tb_ps2_host_tx;

  localparam int INH       = 40;
  localparam int TMO       = 1500;
  localparam int SYNC      = 2;
  localparam int HALF      = 15;
  localparam int DEV_LIMIT = 4 * TMO;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_ABORT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0;
  int run = 0, last_inh = 0, inh_runs = 0, rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and inhibit-run tracker, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (done && err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) run <= run + 1;
    else if (run != 0) begin
      last_inh <= run;
      inh_runs <= inh_runs + 1;
      rel_cyc  <= cyc;
      run      <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame as the device sees it on rising edges: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ones += int'(d[i]);
      f[i+1] = d[i];
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic device(input int mode, input int runs_before, output logic [10:0] bits);
    int t = 0;
    bits = '0;
    while (inh_runs <= runs_before && t < DEV_LIMIT) begin
      @(negedge clk);
      t++;
    end
    chk("inhibit_seen", 32'(inh_runs > runs_before), 1);
    bits[0] = ps2_data_line;
    if (mode == M_SILENT) return;
    for (int k = 1; k <= 11; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      if (mode == M_ABORT && k == 5) return;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = ps2_data_line;
      if (k == 10) dev_data_low = (mode == M_ACK);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic accept(input logic [7:0] d);
    int t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (tx_ready && t < 100);
    chk("accepted", tx_ready, 0);
    tx_valid = 1'b0;
  endtask

  task automatic wait_outcome(input int base, input int limit);
    int t = 0;
    while (done_cnt + err_cnt == base && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) begin
      total++;
      bad++;
      $display("FAIL outcome_wait: no done/err within %0d cycles", limit);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int mode, output logic [10:0] bits);
    int r0 = inh_runs, bd = done_cnt, be = err_cnt;
    int attempts = (mode == M_ACK) ? 1 : ATTEMPTS;
    accept(d);
    for (int a = 0; a < attempts; a++) begin
      device(mode, r0 + a, bits);
      chk("inhibit_len", last_inh, INH);
      if (mode != M_SILENT) chk("frame_bits", 32'(bits), 32'(model_frame(d)));
    end
    wait_outcome(bd + be, DEV_LIMIT);
    @(negedge clk);
    chk("done_pulses", done_cnt - bd, 32'(mode == M_ACK));
    chk("err_pulses", err_cnt - be, 32'(mode != M_ACK));
    chk("tx_ready_after", tx_ready, 1);
    chk("oe_after", {ps2_clk_oe, ps2_data_oe}, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic       exp_par;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [10:0] bits;
    int         r0, bd, t;

    vecs[0] = '{8'hED, M_ACK, 1'b1};
    vecs[1] = '{8'h00, M_ACK, 1'b1};
    vecs[2] = '{8'hFF, M_ACK, 1'b1};
    vecs[3] = '{8'h01, M_ACK, 1'b0};
    vecs[4] = '{8'hF4, M_NACK, 1'b0};

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, err}, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].mode, bits);
      chk("parity_bit", bits[9], vecs[i].exp_par);
    end

    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, bits);
    end

    // Device never clocks: err follows the final clock release by the timeout window.
    send_frame(8'h3C, M_SILENT, bits);
    chk("timeout_window", 32'((err_cyc - rel_cyc) >= TMO && (err_cyc - rel_cyc) <= TMO + SYNC + 3), 1);

    // Reset at fall 5 of a 0xFF frame releases everything immediately.
    r0 = inh_runs;
    accept(8'hFF);
    device(M_ABORT, r0, bits);
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'hF4, M_ACK, bits);

    // tx_valid held with 0xAA while 0x55 is in flight.
    r0 = inh_runs;
    bd = done_cnt;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tx_ready && t < 100);
    tx_data = 8'hAA;
    device(M_ACK, r0, bits);
    chk("held_first_frame", 32'(bits), 32'(model_frame(8'h55)));
    t = 0;
    while ((done_cnt == bd || tx_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("second_accept_after_done", done_cnt - bd, 1);
    tx_valid = 1'b0;
    device(M_ACK, r0 + 1, bits);
    chk("held_second_frame", 32'(bits), 32'(model_frame(8'hAA)));
    wait_outcome(bd + 1 + err_cnt, DEV_LIMIT);
    @(negedge clk);
    chk("held_done_total", done_cnt - bd, 2);

    chk("done_err_overlap", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
